data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-requester arbiter that shares the single-port 8-bit data memory between the processor core's load/store stage (port C) and a secondary master such as a memory-init/debug loader (port D). Port C has fixed priority, and a starvation counter guarantees port D forward progress. The block drives the memory's address, write-data and write-enable inputs, and returns read data to the winner one cycle later through a registered read-valid path.

## Interface
Parameters:
- ADDR_W, 8, address width; matches the data memory depth 2**ADDR_W.
- DATA_W, 8, data width.
- MAX_WAIT, 4, number of consecutive lost cycles after which port D wins the next contention; legal range 1..15.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- c_req  in  1  core request; held high until c_gnt is seen.
- c_wen  in  1  core write (1) / read (0).
- c_addr  in  ADDR_W  core address.
- c_wdata  in  DATA_W  core write data.
- c_gnt  out  1  combinational grant; the access executes this cycle.
- c_rdata  out  DATA_W  registered read data.
- c_rvalid  out  1  one-cycle pulse; c_rdata is valid.
- d_req, d_wen, d_addr, d_wdata, d_gnt, d_rdata, d_rvalid: same meaning for port D.
- mem_addr  out  ADDR_W  to the memory address input.
- mem_wdata  out  DATA_W  to the memory write-data input.
- mem_wen  out  1  to the memory write-control input.
- mem_rdata  in  DATA_W  combinational read data from the memory.

## Operation
- The arbiter has two states:
  - NORMAL: C wins whenever c_req=1.
  - FORCE_D: D wins if d_req=1; otherwise C wins if c_req=1.
- State is derived from wait_cnt:
  - FORCE_D when wait_cnt == MAX_WAIT.
  - NORMAL otherwise.
- wait_cnt update, with width clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, each cycle in which d_req=1 and d_gnt=0.
  - Clears to 0 on any cycle with d_gnt=1 or d_req=0.
- At most one grant per cycle, and c_gnt & d_gnt is never 1.
- Winner's signals are muxed onto the memory bus:
  - mem_addr = winner addr.
  - mem_wdata = winner wdata.
  - mem_wen = winner wen & gnt.
- With no grant, mem_addr=0, mem_wdata=0, mem_wen=0.
- Read grant (wen=0): mem_rdata is captured into the winner's rdata register at the posedge ending the grant cycle, and that port's rvalid is set for exactly one cycle.
- Write grant: rvalid stays 0 and the rdata registers hold their value.
- The non-winning port's rdata register is unchanged.
- A request dropped before grant has no effect. A requester keeps addr/wen/wdata stable while req=1.
- Simultaneous requests to the same address are serialised by priority. If C writes in cycle N, a D read of that address granted in N+1 returns the new value.

## Timing
- Grant latency: 0 cycles when uncontended (gnt is combinational from req and wait_cnt).
- A write commits to memory at the posedge ending the grant cycle.
- Read data latency: a grant in cycle N gives rvalid=1 and rdata valid in cycle N+1.
- Under continuous c_req, D waits at most MAX_WAIT cycles, then is granted on cycle MAX_WAIT+1 of its request.
- Back-to-back grants to the same port on consecutive cycles are legal, so a port can sustain 1 access per cycle.
- Reset values, applied at the posedge while RESET=1: wait_cnt=0, c_rvalid=0, d_rvalid=0, c_rdata=0, d_rdata=0.
- While RESET=1, c_gnt=0, d_gnt=0 and mem_wen=0 (combinational gate), so no write occurs in a reset cycle.
- Reset asserted in a read-grant cycle: the rvalid pulse is suppressed.

## Structure
- Shared package dmem_pkg:
  - ADDR_W and DATA_W defaults.
  - Port enum (PORT_C, PORT_D).
  - arb_state_e (NORMAL, FORCE_D).
- The package is also used by data memory users.
- One sub-module, dmem_starve_ctr: the saturating wait counter with inc/clr/sat. The remaining logic (grant, mux, read-return registers) lives in the top.

## Test plan
- After reset, idle inputs -> all outputs 0, mem_wen=0.
- C write addr 0x10 data 0xA5 in cycle 1, C read 0x10 in cycle 2 -> c_gnt=1 both cycles, c_rvalid=1 in cycle 3 with c_rdata=0xA5, d_rvalid=0.
- c_req and d_req held continuously, MAX_WAIT=4:
  - c_gnt in cycles 1–4.
  - d_gnt in cycle 5, with wait_cnt=0 in cycle 6.
  - The pattern repeats (C ×4, D ×1).
- C write 0x20=0x3C with a simultaneous D read of 0x20 -> C granted first, D granted next cycle, d_rdata=0x3C one cycle later.
- RESET high during a D read grant -> d_gnt=0, mem_wen=0, d_rvalid stays 0, wait_cnt=0 afterwards.
- d_req dropped after 2 lost cycles, then reasserted -> wait_cnt restarts from 0, so D is forced only after 4 further lost cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and default widths for the 8-bit data memory and
//            the masters that access it.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Default geometry of the data memory (depth is 2**DMEM_ADDR_W).
   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 8;

   // Identifies which requester owns the memory bus in a given cycle.
   typedef enum logic {
      PORT_C = 1'b0,
      PORT_D = 1'b1
   } port_e;

   // Arbitration mode; FORCE_D hands the next contention to port D.
   typedef enum logic {
      NORMAL  = 1'b0,
      FORCE_D = 1'b1
   } arb_state_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : dmem_starve_ctr
// Brief    : Saturating count of consecutive cycles in which port D asked for
//            the memory and lost; o_sat flags that D must win next contention.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_starve_ctr #(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic i_inc,
   input  logic i_clr,
   output logic o_sat
);

   localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] r_cnt;

   assign o_sat = (r_cnt == C_MAX);

   // Count lost cycles; a clear (grant or request withdrawn) dominates.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && !o_sat) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule : dmem_starve_ctr
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Shares a single-port data memory between the core load/store
//            port (C, fixed priority) and a secondary master (D) with a
//            starvation guard. Read data returns one cycle after the grant.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int MAX_WAIT = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   // port C: core load/store stage
   input  logic              c_req,
   input  logic              c_wen,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic [DATA_W-1:0] c_rdata,
   output logic              c_rvalid,
   // port D: secondary master
   input  logic              d_req,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_rvalid,
   // memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wen,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e        w_state;
   port_e             w_winner;
   logic              w_sat;
   logic              w_c_gnt;
   logic              w_d_gnt;
   logic              w_any_gnt;
   logic              r_c_rvalid;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_c_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   // The lost-cycle counter saturating is what puts D in front of C.
   dmem_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve_ctr (
      .clk   (CLK),
      .rst   (RESET),
      .i_inc (d_req & ~w_d_gnt),
      .i_clr (w_d_gnt | ~d_req),
      .o_sat (w_sat)
   );

   // Arbitration mode is a pure function of the starvation counter.
   always_comb begin
      w_state = w_sat ? FORCE_D : NORMAL;
   end

   // Grant decision; reset gates both grants so nothing reaches memory.
   always_comb begin
      w_c_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (!RESET) begin
         if (w_state == FORCE_D && d_req) begin
            w_d_gnt = 1'b1;
         end else if (c_req) begin
            w_c_gnt = 1'b1;
         end else if (d_req) begin
            w_d_gnt = 1'b1;
         end
      end
   end

   assign w_any_gnt = w_c_gnt | w_d_gnt;
   assign w_winner  = w_d_gnt ? PORT_D : PORT_C;

   // Drive the winner onto the memory bus; an idle bus is all zeros.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wen   = 1'b0;
      if (w_any_gnt) begin
         if (w_winner == PORT_D) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wen   = d_wen;
         end else begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_wen   = c_wen;
         end
      end
   end

   // Capture read data for the port that was granted a read this cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_c_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_c_rdata  <= '0;
         r_d_rdata  <= '0;
      end else begin
         r_c_rvalid <= w_c_gnt & ~c_wen;
         r_d_rvalid <= w_d_gnt & ~d_wen;
         if (w_c_gnt && !c_wen) begin
            r_c_rdata <= mem_rdata;
         end
         if (w_d_gnt && !d_wen) begin
            r_d_rdata <= mem_rdata;
         end
      end
   end

   assign c_gnt    = w_c_gnt;
   assign d_gnt    = w_d_gnt;
   assign c_rvalid = r_c_rvalid;
   assign d_rvalid = r_d_rvalid;
   assign c_rdata  = r_c_rdata;
   assign d_rdata  = r_d_rdata;

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Self-checking bench for data_mem_arbiter: directed scenarios
//            plus constrained-random traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

   localparam int MAX_WAIT = 4;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       c_req = 1'b0, c_wen = 1'b0;
   logic [7:0] c_addr = '0, c_wdata = '0;
   logic       d_req = 1'b0, d_wen = 1'b0;
   logic [7:0] d_addr = '0, d_wdata = '0;
   logic       c_gnt, c_rvalid, d_gnt, d_rvalid, mem_wen;
   logic [7:0] c_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int failures = 0;

   data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
      .CLK(CLK), .RESET(RESET),
      .c_req(c_req), .c_wen(c_wen), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
      .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   // Memory device: asynchronous read, write on the rising edge.
   logic [7:0] tb_mem [256];
   assign mem_rdata = tb_mem[mem_addr];
   always @(posedge CLK) if (mem_wen) tb_mem[mem_addr] <= mem_wdata;

   // Behavioural model: golden memory contents, D's lost-cycle count, and
   // the read-return values each port should currently present.
   logic [7:0] ref_mem [256];
   int         m_lost = 0;
   logic       m_cv = 1'b0, m_dv = 1'b0;
   logic [7:0] m_cr = '0, m_dr = '0;
   logic       e_cg, e_dg, e_wen;
   logic [7:0] e_addr, e_wdata;

   // Expected combinational outputs for the inputs currently applied.
   task automatic model_eval();
      e_cg = 1'b0;
      e_dg = 1'b0;
      if (!RESET) begin
         if (d_req && m_lost >= MAX_WAIT) e_dg = 1'b1;
         else if (c_req)                  e_cg = 1'b1;
         else if (d_req)                  e_dg = 1'b1;
      end
      e_addr  = e_cg ? c_addr  : (e_dg ? d_addr  : 8'h00);
      e_wdata = e_cg ? c_wdata : (e_dg ? d_wdata : 8'h00);
      e_wen   = (e_cg && c_wen) || (e_dg && d_wen);
   endtask

   // Effect of the clock edge on the model.
   task automatic model_commit();
      if (RESET) begin
         m_lost = 0; m_cv = 1'b0; m_dv = 1'b0; m_cr = '0; m_dr = '0;
      end else begin
         m_cv = e_cg && !c_wen;
         m_dv = e_dg && !d_wen;
         if (m_cv) m_cr = ref_mem[c_addr];
         if (m_dv) m_dr = ref_mem[d_addr];
         if (e_wen) ref_mem[e_addr] = e_wdata;
         if (e_dg || !d_req) m_lost = 0;
         else if (m_lost < MAX_WAIT) m_lost = m_lost + 1;
      end
   endtask

   task automatic settle();
      @(negedge CLK);
      model_eval();
   endtask

   task automatic advance();
      @(posedge CLK);
      model_commit();
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin settle(); advance(); end
   endtask

   task automatic set_c(input logic req, input logic wen, input logic [7:0] a, input logic [7:0] wd);
      c_req = req; c_wen = wen; c_addr = a; c_wdata = wd;
   endtask

   task automatic set_d(input logic req, input logic wen, input logic [7:0] a, input logic [7:0] wd);
      d_req = req; d_wen = wen; d_addr = a; d_wdata = wd;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      set_c(1, 1, 8'h33, 8'h44);
      set_d(1, 1, 8'h55, 8'h66);
      settle();
      checks++; if ({c_gnt, d_gnt, mem_wen} !== 3'b000) begin failures++;
         $display("FAIL reset_gate: gnt/wen=%b expected 000", {c_gnt, d_gnt, mem_wen}); end
      advance();
      set_c(0, 0, 0, 0);
      set_d(0, 0, 0, 0);
      settle(); advance();
      RESET = 1'b0;
      settle();
      checks++; if ({c_gnt, d_gnt, mem_wen, c_rvalid, d_rvalid} !== 5'b0) begin failures++;
         $display("FAIL reset_ctrl: got %b expected 00000", {c_gnt, d_gnt, mem_wen, c_rvalid, d_rvalid}); end
      checks++; if ({mem_addr, mem_wdata, c_rdata, d_rdata} !== 32'h0) begin failures++;
         $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, c_rdata, d_rdata}); end
      advance();
   endtask

   task automatic test_write_read();
      set_c(1, 1, 8'h10, 8'hA5);
      settle();
      checks++; if ({c_gnt, d_gnt, mem_wen, mem_addr, mem_wdata} !== {3'b101, 8'h10, 8'hA5}) begin failures++;
         $display("FAIL wr_bus: got %b %h %h expected 101 10 a5", {c_gnt, d_gnt, mem_wen}, mem_addr, mem_wdata); end
      advance();
      set_c(1, 0, 8'h10, 8'h00);
      settle();
      checks++; if ({c_gnt, mem_wen, c_rvalid} !== 3'b100) begin failures++;
         $display("FAIL rd_grant: got %b expected 100", {c_gnt, mem_wen, c_rvalid}); end
      advance();
      set_c(0, 0, 0, 0);
      settle();
      checks++; if ({c_rvalid, d_rvalid, c_rdata} !== {2'b10, 8'hA5}) begin failures++;
         $display("FAIL rd_return: rvalid=%b rdata=%h expected 10 a5", {c_rvalid, d_rvalid}, c_rdata); end
      advance();
      settle();
      checks++; if (c_rvalid !== 1'b0) begin failures++;
         $display("FAIL rvalid_pulse: got %b expected 0", c_rvalid); end
      advance();
   endtask

   task automatic test_same_addr();
      set_c(1, 1, 8'h20, 8'h3C);
      set_d(1, 0, 8'h20, 8'h00);
      settle();
      checks++; if ({c_gnt, d_gnt} !== 2'b10) begin failures++;
         $display("FAIL same_addr_first: gnt=%b expected 10", {c_gnt, d_gnt}); end
      advance();
      set_c(0, 0, 0, 0);
      settle();
      checks++; if ({c_gnt, d_gnt, mem_addr} !== {2'b01, 8'h20}) begin failures++;
         $display("FAIL same_addr_second: gnt=%b addr=%h expected 01 20", {c_gnt, d_gnt}, mem_addr); end
      advance();
      set_d(0, 0, 0, 0);
      settle();
      checks++; if ({d_rvalid, c_rvalid, d_rdata} !== {2'b10, 8'h3C}) begin failures++;
         $display("FAIL same_addr_data: rvalid=%b rdata=%h expected 10 3c", {d_rvalid, c_rvalid}, d_rdata); end
      advance();
   endtask

   // Both ports continuously requesting from a clean counter: C x4, D x1.
   task automatic test_starvation();
      idle_cycles(1);
      set_c(1, 0, 8'h01, 0);
      set_d(1, 0, 8'h02, 0);
      for (int k = 0; k < 10; k++) begin
         settle();
         checks++; if ({c_gnt, d_gnt} !== ((k % 5 == 4) ? 2'b01 : 2'b10)) begin failures++;
            $display("FAIL starve_cycle%0d: gnt=%b expected %b", k + 1, {c_gnt, d_gnt}, (k % 5 == 4) ? 2'b01 : 2'b10); end
         advance();
      end
      set_c(0, 0, 0, 0); set_d(0, 0, 0, 0);
      idle_cycles(1);
   endtask

   // Withdrawing D's request discards its accumulated wait.
   task automatic test_drop();
      set_c(1, 0, 8'h05, 0);
      set_d(1, 0, 8'h06, 0);
      idle_cycles(2);
      set_d(0, 0, 0, 0);
      idle_cycles(1);
      set_d(1, 0, 8'h07, 0);
      for (int k = 0; k < 5; k++) begin
         settle();
         checks++; if ({c_gnt, d_gnt} !== ((k == 4) ? 2'b01 : 2'b10)) begin failures++;
            $display("FAIL drop_cycle%0d: gnt=%b expected %b", k + 1, {c_gnt, d_gnt}, (k == 4) ? 2'b01 : 2'b10); end
         advance();
      end
      set_c(0, 0, 0, 0); set_d(0, 0, 0, 0);
      idle_cycles(1);
   endtask

   // Reset landing on a D read grant, after D has already lost two cycles.
   task automatic test_reset_during_read();
      set_c(1, 0, 8'h08, 0);
      set_d(1, 0, 8'h09, 0);
      idle_cycles(2);
      set_c(0, 0, 0, 0);
      RESET = 1'b1;
      settle();
      checks++; if ({d_gnt, c_gnt, mem_wen} !== 3'b000) begin failures++;
         $display("FAIL rst_rd_gate: gnt/wen=%b expected 000", {d_gnt, c_gnt, mem_wen}); end
      advance();
      RESET = 1'b0;
      set_c(1, 0, 8'h0A, 0);
      for (int k = 0; k < 5; k++) begin
         settle();
         if (k == 0) begin
            checks++; if (d_rvalid !== 1'b0) begin failures++;
               $display("FAIL rst_rd_rvalid: got %b expected 0", d_rvalid); end
         end
         checks++; if ({c_gnt, d_gnt} !== ((k == 4) ? 2'b01 : 2'b10)) begin failures++;
            $display("FAIL rst_cnt_cycle%0d: gnt=%b expected %b", k + 1, {c_gnt, d_gnt}, (k == 4) ? 2'b01 : 2'b10); end
         advance();
      end
      set_c(0, 0, 0, 0); set_d(0, 0, 0, 0);
      idle_cycles(1);
   endtask

   // Port D alone streaming one read per cycle.
   task automatic test_back_to_back();
      for (int k = 0; k < 4; k++) begin
         set_d(1, 0, 8'h40 + 8'(k), 0);
         settle();
         checks++; if (d_gnt !== 1'b1) begin failures++;
            $display("FAIL b2b_gnt%0d: got %b expected 1", k, d_gnt); end
         if (k > 0) begin
            checks++; if ({d_rvalid, d_rdata} !== {1'b1, m_dr}) begin failures++;
               $display("FAIL b2b_data%0d: got %b %h expected 1 %h", k, d_rvalid, d_rdata, m_dr); end
         end
         advance();
      end
      set_d(0, 0, 0, 0);
      idle_cycles(1);
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         settle();
         checks++; if ({c_gnt, d_gnt} !== {e_cg, e_dg}) begin failures++;
            $display("FAIL rnd_gnt@%0d: got %b expected %b", n, {c_gnt, d_gnt}, {e_cg, e_dg}); end
         checks++; if ({mem_wen, mem_addr, mem_wdata} !== {e_wen, e_addr, e_wdata}) begin failures++;
            $display("FAIL rnd_bus@%0d: got %b %h %h expected %b %h %h", n, mem_wen, mem_addr, mem_wdata, e_wen, e_addr, e_wdata); end
         checks++; if ({c_rvalid, c_rdata} !== {m_cv, m_cr}) begin failures++;
            $display("FAIL rnd_c_ret@%0d: got %b %h expected %b %h", n, c_rvalid, c_rdata, m_cv, m_cr); end
         checks++; if ({d_rvalid, d_rdata} !== {m_dv, m_dr}) begin failures++;
            $display("FAIL rnd_d_ret@%0d: got %b %h expected %b %h", n, d_rvalid, d_rdata, m_dv, m_dr); end
         advance();
         // Requesters hold until granted (occasionally giving up), else start anew.
         if (c_req && !e_cg && $urandom_range(0, 7) != 0) begin end
         else if ($urandom_range(0, 99) < 75)
            set_c(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
         else set_c(0, 0, 0, 0);
         if (d_req && !e_dg && $urandom_range(0, 7) != 0) begin end
         else if ($urandom_range(0, 99) < 70)
            set_d(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
         else set_d(0, 0, 0, 0);
         RESET = ($urandom_range(0, 59) == 0);
      end
      RESET = 1'b0;
      set_c(0, 0, 0, 0); set_d(0, 0, 0, 0);
      idle_cycles(1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         tb_mem[i]  = 8'($urandom);
         ref_mem[i] = tb_mem[i];
      end
      test_reset();
      test_write_read();
      test_same_addr();
      test_starvation();
      test_drop();
      test_reset_during_read();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_data_mem_arbiter
`default_nettype wire
